// File: rtl/nand2_rr_arbiter.sv
// Round-robin arbiter that time-shares one registered W-bit NAND unit among N_REQ requesters.
// The registered grant doubles as the mask, so a requester is never granted on back-to-back edges.
module nand2_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 1,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*W-1:0]   a_bus,
  input  logic [N_REQ*W-1:0]   b_bus,
  output logic [N_REQ-1:0]     gnt,
  output logic [W-1:0]         y,
  output logic                 y_valid,
  output logic [ID_W-1:0]      y_id
);

  logic [ID_W-1:0]  ptr_reg;
  logic [ID_W-1:0]  ptr_next;
  logic [N_REQ-1:0] eligible;
  logic             found;
  logic [ID_W-1:0]  win_idx;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;

  assign eligible = req & ~gnt;

  // Search eligible starting at ptr_reg, wrapping; the first hit wins.
  // Only the winning lane is extracted, so other lanes never reach y.
  always_comb begin
    int idx;
    found   = 1'b0;
    win_idx = '0;
    op_a    = '0;
    op_b    = '0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_reg) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && (|((eligible >> idx) & N_REQ'(1)))) begin
        found   = 1'b1;
        win_idx = ID_W'(idx);
        op_a    = W'(a_bus >> (idx * W));
        op_b    = W'(b_bus >> (idx * W));
      end
    end
  end

  assign ptr_next = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      y_id    <= '0;
      ptr_reg <= '0;
    end else if (found) begin
      gnt     <= N_REQ'(1) << win_idx;
      y       <= ~(op_a & op_b);
      y_valid <= 1'b1;
      y_id    <= win_idx;
      ptr_reg <= ptr_next;
    end else begin
      gnt     <= '0;
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nand2_rr_arbiter.sv
// Self-checking bench: directed vector table, hand sequences and randomized traffic vs. a reference model.
module tb_nand2_rr_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [N-1:0] req, a_bus, b_bus, gnt;
  logic         y, y_valid;
  logic [1:0]   y_id;

  logic r1, a1, b1, g1, y1, v1, id1;

  nand2_rr_arbiter #(.N_REQ(N), .W(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .gnt(gnt), .y(y), .y_valid(y_valid), .y_id(y_id)
  );

  nand2_rr_arbiter #(.N_REQ(1), .W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(r1), .a_bus(a1), .b_bus(b1),
    .gnt(g1), .y(y1), .y_valid(v1), .y_id(id1)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: next search start, last granted index (-1 if none), held outputs.
  int   m_ptr  = 0;
  int   m_last = -1;
  int   m_id   = 0;
  logic m_y    = 1'b0;
  logic m_val  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    int k;
    int win;
    win = -1;
    if (!rst_n) begin
      m_ptr = 0; m_last = -1; m_id = 0; m_y = 1'b0; m_val = 1'b0;
    end else begin
      for (int o = 0; o < N; o++) begin
        k = (m_ptr + o) % N;
        if (win < 0 && req[k] && k != m_last) win = k;
      end
      if (win >= 0) begin
        m_last = win;
        m_id   = win;
        m_y    = ~(a_bus[win] & b_bus[win]);
        m_val  = 1'b1;
        m_ptr  = (win + 1) % N;
      end else begin
        m_last = -1;
        m_val  = 1'b0;
      end
    end
  endtask

  function automatic int model_gnt();
    return m_val ? (1 << m_last) : 0;
  endfunction

  task automatic tick(input logic r, input logic [N-1:0] q, input logic [N-1:0] aa, input logic [N-1:0] bb);
    rst_n = r; req = q; a_bus = aa; b_bus = bb;
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] req, a, b, gnt;
    logic         y, valid;
    logic [1:0]   id;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rs, logic [3:0] q, logic [3:0] aa, logic [3:0] bb,
                              logic [3:0] g, logic yy, logic v, logic [1:0] i);
    vec_t t;
    t.rst = rs; t.req = q; t.a = aa; t.b = bb; t.gnt = g; t.y = yy; t.valid = v; t.id = i;
    return t;
  endfunction

  initial begin
    int pulses;
    logic [N-1:0] q;
    logic rr;

    rst_n = 1'b0; req = '0; a_bus = '0; b_bus = '0;
    r1 = 1'b0; a1 = 1'b0; b1 = 1'b0;

    // Reset with all requests high, then single op, truth table, reset mid-stream,
    // lone requester, and two-requester rotation.
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b1100, 4'b1010, 4'b0001, 1, 1, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b1100, 4'b1010, 4'b0010, 1, 1, 1));
    tbl.push_back(mk(1, 4'b1111, 4'b1100, 4'b1010, 4'b0100, 1, 1, 2));
    tbl.push_back(mk(1, 4'b1111, 4'b1100, 4'b1010, 4'b1000, 0, 1, 3));
    tbl.push_back(mk(1, 4'b1111, 4'b1100, 4'b1010, 4'b0001, 1, 1, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b1100, 4'b1010, 4'b0010, 1, 1, 1));
    tbl.push_back(mk(0, 4'b1111, 4'b1100, 4'b1010, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b1100, 4'b1010, 4'b0001, 1, 1, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 4'b0100, 4'b0100, 4'b0100, (i % 2 == 0) ? 4'b0100 : 4'b0000, 0, (i % 2 == 0), 2));
    tbl.push_back(mk(1, 4'b1001, 4'b1001, 4'b0001, 4'b1000, 1, 1, 3));
    tbl.push_back(mk(1, 4'b1001, 4'b1001, 4'b0001, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(1, 4'b1001, 4'b1001, 4'b0001, 4'b1000, 1, 1, 3));
    tbl.push_back(mk(1, 4'b1001, 4'b1001, 4'b0001, 4'b0001, 0, 1, 0));

    foreach (tbl[i]) begin
      tick(tbl[i].rst, tbl[i].req, tbl[i].a, tbl[i].b);
      $display("vec %0d: rst_n=%b req=%b gnt=%b y=%b valid=%b id=%0d", i, tbl[i].rst, tbl[i].req, gnt, y, y_valid, y_id);
      check($sformatf("vec%0d_gnt", i), gnt, tbl[i].gnt);
      check($sformatf("vec%0d_y", i), y, tbl[i].y);
      check($sformatf("vec%0d_valid", i), y_valid, tbl[i].valid);
      check($sformatf("vec%0d_id", i), y_id, tbl[i].id);
    end

    // Client drops its request as soon as it sees its grant: exactly one result.
    tick(0, '0, '0, '0);
    q = 4'b0010;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1, q, 4'b0010, 4'b0000);
      $display("client cycle %0d: req=%b gnt=%b y=%b valid=%b id=%0d", i, q, gnt, y, y_valid, y_id);
      if (y_valid) begin
        pulses++;
        check("client_y", y, 1);
        check("client_id", y_id, 1);
      end
      if (gnt[1]) q = 4'b0000;
    end
    check("client_pulses", pulses, 1);

    // Single-requester instance: granted only on alternate cycles.
    tick(0, '0, '0, '0);
    r1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1, '0, '0, '0);
      $display("single cycle %0d: gnt=%b y=%b valid=%b", i, g1, y1, v1);
      check("single_valid", v1, (i % 2 == 0) ? 1 : 0);
      check("single_gnt", g1, (i % 2 == 0) ? 1 : 0);
      check("single_y", y1, 1);
    end
    r1 = 1'b0;

    // Randomized traffic with occasional resets against the model.
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 39) != 0);
      tick(rr, N'($urandom), N'($urandom), N'($urandom));
      $display("rand %0d: rst_n=%b req=%b gnt=%b y=%b valid=%b id=%0d", i, rr, req, gnt, y, y_valid, y_id);
      check("rand_gnt", gnt, model_gnt());
      check("rand_valid", y_valid, m_val);
      check("rand_y", y, m_y);
      check("rand_id", y_id, m_id);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
